// File: rtl/shift_flush_ctrl_if.sv
// Pixel-stream bus between the upstream source, the flush controller and the
// downstream window-buffer shift FIFO.
interface shift_flush_ctrl_if #(
    parameter int PXL_CHANNEL = 8
);
    logic                         i_enable_rx;
    logic [2:0][PXL_CHANNEL-1:0]  i_data;
    logic                         i_frame_end;
    logic                         o_ready;
    logic                         o_enable_tx;
    logic [2:0][PXL_CHANNEL-1:0]  o_data;
    logic                         o_flushing;
    logic                         o_flush_done;

    modport slave (
        input  i_enable_rx, i_data, i_frame_end,
        output o_ready, o_enable_tx, o_data, o_flushing, o_flush_done
    );

    modport master (
        output i_enable_rx, i_data, i_frame_end,
        input  o_ready, o_enable_tx, o_data, o_flushing, o_flush_done
    );
endinterface

// File: rtl/shift_flush_ctrl.sv
// Registered pixel pass-through that, on frame end, stalls upstream and injects
// FLUSH_DEPTH pad samples to push residual pixels out of the shift FIFO.
module shift_flush_ctrl #(
    parameter int PXL_CHANNEL = 8,
    parameter int FLUSH_DEPTH = 640,
    parameter int PAD_VALUE   = 0
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    shift_flush_ctrl_if.slave   bus
);
    localparam int CW = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CW-1:0]          DEPTH_C = CW'(FLUSH_DEPTH);
    localparam logic [CW-1:0]          ONE_C   = CW'(1);
    localparam logic [PXL_CHANNEL-1:0] PAD_C   = PXL_CHANNEL'(PAD_VALUE);

    typedef enum logic [0:0] {
        PASS  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                       state_r, state_s;
    logic [CW-1:0]                cnt_r, cnt_s;
    logic                         enable_tx_r, enable_tx_s;
    logic [2:0][PXL_CHANNEL-1:0]  data_r, data_s;
    logic                         flush_done_r, flush_done_s;

    // State register and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= PASS;
            cnt_r        <= '0;
            enable_tx_r  <= 1'b0;
            data_r       <= '0;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            enable_tx_r  <= enable_tx_s;
            data_r       <= data_s;
            flush_done_r <= flush_done_s;
        end
    end

    // Next-state and next-output logic; pixels arriving during FLUSH are dropped
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enable_tx_s  = 1'b0;
        data_s       = data_r;
        flush_done_s = 1'b0;
        case (state_r)
            PASS: begin
                enable_tx_s = bus.i_enable_rx;
                if (bus.i_enable_rx) begin
                    data_s = bus.i_data;
                end else begin
                    data_s = data_r;
                end
                if (bus.i_frame_end) begin
                    state_s = FLUSH;
                    cnt_s   = DEPTH_C;
                end else begin
                    state_s = PASS;
                end
            end
            FLUSH: begin
                enable_tx_s = 1'b1;
                data_s      = {3{PAD_C}};
                cnt_s       = cnt_r - ONE_C;
                // Exiting on the last pad keeps the counter from ever wrapping
                if (cnt_r == ONE_C) begin
                    state_s      = PASS;
                    flush_done_s = 1'b1;
                end else begin
                    state_s      = FLUSH;
                    flush_done_s = 1'b0;
                end
            end
            default: begin
                state_s = PASS;
                cnt_s   = '0;
            end
        endcase
    end

    assign bus.o_ready      = (state_r == PASS);
    assign bus.o_flushing   = (state_r == FLUSH);
    assign bus.o_enable_tx  = enable_tx_r;
    assign bus.o_data       = data_r;
    assign bus.o_flush_done = flush_done_r;
endmodule

// File: tb/tb_shift_flush_ctrl.sv
// Directed bench for shift_flush_ctrl with FLUSH_DEPTH=4: vector table for the
// pass-through/flush sequence plus hand sequences for violation and reset cases.
module tb_shift_flush_ctrl;
    localparam int PXL = 8;
    localparam int FD  = 4;

    logic i_clk;
    logic i_reset_n;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   viol_cnt  = 0;

    shift_flush_ctrl_if #(.PXL_CHANNEL(PXL)) bus ();

    shift_flush_ctrl #(
        .PXL_CHANNEL(PXL),
        .FLUSH_DEPTH(FD),
        .PAD_VALUE  (0)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .bus      (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Protocol monitor: pixel offered while the controller is flushing
    always @(posedge i_clk) begin
        if (i_reset_n && bus.i_enable_rx && bus.o_flushing) begin
            viol_cnt <= viol_cnt + 1;
            $display("protocol note: i_enable_rx high during flush at %0t", $time);
        end
    end

    typedef struct {
        logic        en;
        logic [23:0] data;
        logic        fe;
        logic        exp_en;
        logic [23:0] exp_data;
        logic        exp_ready;
        logic        exp_done;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic en, logic [23:0] d, logic fe,
                                logic xen, logic [23:0] xd, logic xr, logic xdone);
        vec_t v;
        v.en = en; v.data = d; v.fe = fe;
        v.exp_en = xen; v.exp_data = xd; v.exp_ready = xr; v.exp_done = xdone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic chk_all(input string tag, input logic xen, input logic [23:0] xd,
                           input logic xr, input logic xdone);
        chk({tag, ".en"},    {31'd0, bus.o_enable_tx},  {31'd0, xen});
        chk({tag, ".data"},  {8'd0, bus.o_data},        {8'd0, xd});
        chk({tag, ".ready"}, {31'd0, bus.o_ready},      {31'd0, xr});
        chk({tag, ".flush"}, {31'd0, bus.o_flushing},   {31'd0, ~xr});
        chk({tag, ".done"},  {31'd0, bus.o_flush_done}, {31'd0, xdone});
    endtask

    task automatic drive(input logic en, input logic [23:0] d, input logic fe);
        bus.i_enable_rx = en;
        bus.i_data      = d;
        bus.i_frame_end = fe;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int pads;
        int dones;
        int bad;
        int done_at;
        logic [23:0] px;

        drive(1'b0, 24'h000000, 1'b0);
        i_reset_n = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 24'h000000, 1'b1, 1'b0);
        i_reset_n = 1'b1;
        tick();

        // Pixels 1..9, idle, pixel 10 with frame end, 4 pads, back-to-back pixel
        for (int k = 1; k <= 9; k++) begin
            px = {8'(k), 8'(k + 1), 8'(k + 2)};
            vq.push_back(mk(1'b1, px, 1'b0, 1'b1, px, 1'b1, 1'b0));
        end
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b0, 24'h090A0B, 1'b1, 1'b0));
        vq.push_back(mk(1'b1, 24'h0A0B0C, 1'b1, 1'b1, 24'h0A0B0C, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1));
        vq.push_back(mk(1'b1, 24'h112233, 1'b0, 1'b1, 24'h112233, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 24'h000000, 1'b0, 1'b0, 24'h112233, 1'b1, 1'b0));

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].data, vq[i].fe);
            tick();
            chk_all($sformatf("vec%0d", i), vq[i].exp_en, vq[i].exp_data,
                    vq[i].exp_ready, vq[i].exp_done);
        end

        // Empty-frame flush with a dropped pixel and a repeated frame end
        drive(1'b0, 24'h000000, 1'b1);
        tick();
        pads = 0; dones = 0; bad = 0; done_at = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) drive(1'b1, 24'hFFFFFF, 1'b1);
            else        drive(1'b0, 24'h000000, 1'b0);
            tick();
            if (bus.o_data == 24'hFFFFFF) bad++;
            if (bus.o_enable_tx && bus.o_data == 24'h000000) pads++;
            if (bus.o_flush_done) begin
                dones++;
                done_at = pads;
            end
        end
        chk("viol.pads",     pads,     FD);
        chk("viol.dones",    dones,    1);
        chk("viol.done_at",  done_at,  FD);
        chk("viol.ff_seen",  bad,      0);
        chk("viol.flagged",  viol_cnt, 1);
        chk("viol.ready",    {31'd0, bus.o_ready}, 32'd1);

        // Asynchronous reset after the second pad
        drive(1'b0, 24'h000000, 1'b1);
        tick();
        drive(1'b0, 24'h000000, 1'b0);
        tick();
        tick();
        chk("rst.pre_en", {31'd0, bus.o_enable_tx}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 24'h000000, 1'b1, 1'b0);
        tick();
        i_reset_n = 1'b1;
        chk_all("rst.held", 1'b0, 24'h000000, 1'b1, 1'b0);
        dones = 0; pads = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.o_flush_done) dones++;
            if (bus.o_enable_tx) pads++;
        end
        chk("rst.no_done", dones, 0);
        chk("rst.no_tx",   pads,  0);
        chk("rst.ready",   {31'd0, bus.o_ready}, 32'd1);

        drive(1'b0, 24'h000000, 1'b1);
        tick();
        drive(1'b0, 24'h000000, 1'b0);
        pads = 0; dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.o_enable_tx && bus.o_data == 24'h000000) pads++;
            if (bus.o_flush_done) dones++;
        end
        chk("post.pads",  pads,  FD);
        chk("post.dones", dones, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
